// File: rtl/fp_share_arbiter_pkg.sv
// Shared definitions for the two-port floating-point datapath arbiter:
// operation codes, FSM state encoding and result flag bit positions.
package fp_share_arbiter_pkg;

    typedef enum logic [1:0] {
        FP_ADD  = 2'b00,
        FP_MUL  = 2'b01,
        FP_SUB  = 2'b10,
        FP_RSVD = 2'b11
    } fp_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    localparam int FLAG_NEG  = 1;
    localparam int FLAG_ZERO = 0;

endpackage

// File: rtl/fp_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that was not granted last. Purely combinational.
module fp_share_arbiter_rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       any_o
);

    always_comb begin
        any_o   = |valid_i;
        grant_o = 1'b0;
        if (valid_i == 2'b11) begin
            grant_o = ~last_grant_i;
        end else if (valid_i[1]) begin
            grant_o = 1'b1;
        end
    end

endmodule

// File: rtl/fp_share_arbiter.sv
// Shares one fp_add/fp_mul pair between two requesters, one op in flight,
// operands held in registers for LATENCY cycles before result capture.
module fp_share_arbiter
    import fp_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [1:0]       rsp_flags,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    input  logic [WIDTH-1:0] fu_add_result,
    input  logic [WIDTH-1:0] fu_mul_result,
    output logic             busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    fp_op_e           op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       flags_q, flags_d;

    logic             grant;
    logic             any_req;
    logic [1:0]       req_rdy;
    logic [1:0]       rsp_vld;
    fp_op_e           op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] fu_res;
    logic             owner_rsp_rdy;

    fp_share_arbiter_rr_arb2 u_rr (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .any_o        (any_req)
    );

    assign op_sel        = grant ? fp_op_e'(req1_op) : fp_op_e'(req0_op);
    assign a_sel         = grant ? req1_a : req0_a;
    assign b_sel         = grant ? req1_b : req0_b;
    assign owner_rsp_rdy = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        fu_res = '0;
        case (op_q)
            FP_ADD, FP_SUB: fu_res = fu_add_result;
            FP_MUL:         fu_res = fu_mul_result;
            default:        fu_res = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        flags_d      = flags_q;
        req_rdy      = 2'b00;
        rsp_vld      = 2'b00;
        case (state_q)
            S_IDLE: begin
                // ready is only raised toward a valid port, so grant == handshake
                if (any_req) begin
                    req_rdy[grant] = 1'b1;
                    owner_d        = grant;
                    last_grant_d   = grant;
                    cnt_d          = CNT_INIT;
                    op_d           = op_sel;
                    a_d            = a_sel;
                    b_d            = b_sel ^ {(op_sel == FP_SUB), {(WIDTH-1){1'b0}}};
                    state_d        = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    res_d              = fu_res;
                    flags_d[FLAG_NEG]  = fu_res[WIDTH-1];
                    flags_d[FLAG_ZERO] = ~|fu_res[WIDTH-2:0];
                    state_d            = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                rsp_vld[owner_q] = 1'b1;
                if (owner_rsp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            op_q         <= FP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            flags_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            flags_q      <= flags_d;
        end
    end

    // Grant is combinational from valid, so mask it while reset is asserted.
    assign req0_ready = reset_n & req_rdy[0];
    assign req1_ready = reset_n & req_rdy[1];
    assign rsp0_valid = rsp_vld[0];
    assign rsp1_valid = rsp_vld[1];
    assign rsp_result = res_q;
    assign rsp_flags  = flags_q;
    assign fu_a       = a_q;
    assign fu_b       = b_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_share_arbiter.sv
// Directed bench for fp_share_arbiter with a table-driven stand-in for fp_add/fp_mul.
module tb_fp_share_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [1:0]  req_op [2];
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [31:0] rsp_result;
    logic [1:0]  rsp_flags;
    logic [31:0] fu_a, fu_b, fu_add, fu_mul;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    fp_share_arbiter #(.WIDTH(32), .LATENCY(LAT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req0_valid    (req_valid[0]),
        .req1_valid    (req_valid[1]),
        .req0_ready    (req_ready[0]),
        .req1_ready    (req_ready[1]),
        .req0_op       (req_op[0]),
        .req1_op       (req_op[1]),
        .req0_a        (req_a[0]),
        .req0_b        (req_b[0]),
        .req1_a        (req_a[1]),
        .req1_b        (req_b[1]),
        .rsp0_valid    (rsp_valid[0]),
        .rsp1_valid    (rsp_valid[1]),
        .rsp0_ready    (rsp_ready[0]),
        .rsp1_ready    (rsp_ready[1]),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .fu_a          (fu_a),
        .fu_b          (fu_b),
        .fu_add_result (fu_add),
        .fu_mul_result (fu_mul),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known IEEE-754 sums/products; other pairs give arbitrary but distinct values.
    always_comb begin
        case ({fu_a, fu_b})
            {32'h3FC00000, 32'h40100000}: fu_add = 32'h40700000;
            {32'h3F800000, 32'hBF800000}: fu_add = 32'h00000000;
            {32'h3F800000, 32'hC0000000}: fu_add = 32'hBF800000;
            {32'h80000000, 32'h80000000}: fu_add = 32'h80000000;
            default:                      fu_add = fu_a ^ fu_b;
        endcase
        case ({fu_a, fu_b})
            {32'h40000000, 32'h40400000}: fu_mul = 32'h40C00000;
            default:                      fu_mul = fu_a + fu_b + 32'h1;
        endcase
    end

    task automatic run_op(input logic p, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res,
                          input logic [1:0] flg, input logic [31:0] fub, input string nm);
        int waited;
        logic [1:0] pm;
        pm = p ? 2'b10 : 2'b01;
        @(negedge clk);
        req_valid[p] = 1'b1; req_op[p] = op; req_a[p] = a; req_b[p] = b;
        #1;
        waited = 0;
        while (req_ready[p] !== 1'b1 && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        vec_cnt++;
        if (req_ready !== pm) begin
            err_cnt++; $display("FAIL %s req_ready: got %b expected %b", nm, req_ready, pm);
        end
        if (req_ready[p] !== 1'b1) begin
            req_valid[p] = 1'b0;
            return;
        end
        @(posedge clk); #1 req_valid[p] = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({busy, rsp_valid, fu_b} !== {1'b1, 2'b00, fub}) begin
                err_cnt++;
                $display("FAIL %s exec cycle %0d busy/rsp_valid/fu_b: got %b/%b/%h expected 1/00/%h",
                         nm, k, busy, rsp_valid, fu_b, fub);
            end
        end
        @(negedge clk);
        vec_cnt++;
        if (rsp_valid !== pm) begin
            err_cnt++; $display("FAIL %s rsp_valid: got %b expected %b", nm, rsp_valid, pm);
        end
        vec_cnt++;
        if (rsp_result !== res) begin
            err_cnt++; $display("FAIL %s rsp_result: got %h expected %h", nm, rsp_result, res);
        end
        vec_cnt++;
        if (rsp_flags !== flg) begin
            err_cnt++; $display("FAIL %s rsp_flags: got %b expected %b", nm, rsp_flags, flg);
        end
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++; $display("FAIL %s idle after rsp: busy got %b expected 0", nm, busy);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req_op[0] = 2'b00; req_a[0] = 32'h3FC00000; req_b[0] = 32'h40100000;
        req_op[1] = 2'b01; req_a[1] = 32'h40000000; req_b[1] = 32'h40400000;
        #12;
        vec_cnt++;
        if ({req_ready, rsp_valid, busy} !== 5'b0) begin
            err_cnt++; $display("FAIL reset ctrl: got %b expected 00000", {req_ready, rsp_valid, busy});
        end
        vec_cnt++;
        if ({fu_a, fu_b, rsp_result, rsp_flags} !== 98'b0) begin
            err_cnt++; $display("FAIL reset data: got %h %h %h %b expected zeros", fu_a, fu_b, rsp_result, rsp_flags);
        end
        req_valid = 2'b00;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({req_ready, rsp_valid, busy} !== 5'b0) begin
            err_cnt++; $display("FAIL post-reset idle: got %b expected 00000", {req_ready, rsp_valid, busy});
        end
    endtask

    task automatic test_fadd();
        run_op(1'b0, 2'b00, 32'h3FC00000, 32'h40100000, 32'h40700000, 2'b00, 32'h40100000, "fadd_p0");
    endtask

    task automatic test_fmul();
        run_op(1'b1, 2'b01, 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, 32'h40400000, "fmul_p1");
    endtask

    task automatic test_fsub_flags();
        run_op(1'b0, 2'b10, 32'h3F800000, 32'h3F800000, 32'h00000000, 2'b01, 32'hBF800000, "fsub_zero");
        run_op(1'b1, 2'b10, 32'h3F800000, 32'h40000000, 32'hBF800000, 2'b10, 32'hC0000000, "fsub_neg");
        run_op(1'b0, 2'b11, 32'h3FC00000, 32'h40100000, 32'h00000000, 2'b01, 32'h40100000, "rsvd_op");
        run_op(1'b1, 2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 2'b11, 32'h80000000, "neg_zero");
    endtask

    task automatic test_simultaneous();
        logic [1:0]  exp_rdy, exp_rsp;
        logic [31:0] exp_res;
        reset_n = 1'b0;
        req_op[0] = 2'b00; req_a[0] = 32'h3FC00000; req_b[0] = 32'h40100000;
        req_op[1] = 2'b01; req_a[1] = 32'h40000000; req_b[1] = 32'h40400000;
        req_valid = 2'b11;
        @(posedge clk); #1 reset_n = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            exp_rdy = (c % 4 == 0 && c <= 12) ? ((c % 8 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rsp = (c % 4 == 3) ? ((c % 8 == 3) ? 2'b01 : 2'b10) : 2'b00;
            exp_res = (c % 8 == 3) ? 32'h40700000 : 32'h40C00000;
            vec_cnt++;
            if ({req_ready, rsp_valid} !== {exp_rdy, exp_rsp}) begin
                err_cnt++;
                $display("FAIL simul c%0d req_ready/rsp_valid: got %b/%b expected %b/%b",
                         c, req_ready, rsp_valid, exp_rdy, exp_rsp);
            end
            if (exp_rsp != 2'b00) begin
                vec_cnt++;
                if (rsp_result !== exp_res) begin
                    err_cnt++; $display("FAIL simul c%0d rsp_result: got %h expected %h", c, rsp_result, exp_res);
                end
            end
            @(posedge clk); #1;
            if (c == 0) req_valid[0] = 1'b0;
            if (c == 4) req_valid = 2'b11;
            if (c == 8) req_valid[0] = 1'b0;
            if (c == 12) req_valid[1] = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int waited;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        #1;
        vec_cnt++;
        if (req_ready !== 2'b01) begin
            err_cnt++; $display("FAIL bp handshake req_ready: got %b expected 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 2'b10;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({rsp_valid, req_ready, rsp_result, rsp_flags} !== {2'b01, 2'b00, 32'h40700000, 2'b00}) begin
                err_cnt++;
                $display("FAIL bp stall %0d rsp_valid/req_ready/result/flags: got %b/%b/%h/%b expected 01/00/40700000/00",
                         k, rsp_valid, req_ready, rsp_result, rsp_flags);
            end
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({busy, req_ready} !== 3'b010) begin
            err_cnt++; $display("FAIL bp release busy/req_ready: got %b/%b expected 0/10", busy, req_ready);
        end
        @(posedge clk); #1 req_valid[1] = 1'b0;
        waited = 0;
        @(negedge clk);
        while (rsp_valid[1] !== 1'b1 && waited < 10) begin
            @(negedge clk); waited++;
        end
        vec_cnt++;
        if ({rsp_valid, rsp_result} !== {2'b10, 32'h40C00000}) begin
            err_cnt++; $display("FAIL bp port1 follow-up rsp_valid/result: got %b/%h expected 10/40C00000", rsp_valid, rsp_result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        logic [1:0] exp_rdy, exp_rsp;
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        vec_cnt++;
        if (req_ready !== 2'b10) begin
            err_cnt++; $display("FAIL rst_exec handshake req_ready: got %b expected 10", req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++; $display("FAIL rst_exec in EXEC busy: got %b expected 1", busy);
        end
        #1 reset_n = 1'b0;
        #1;
        vec_cnt++;
        if ({busy, req_ready, rsp_valid, fu_a, fu_b, rsp_result, rsp_flags} !== 103'b0) begin
            err_cnt++;
            $display("FAIL rst_exec async clear: got busy=%b rdy=%b rsp=%b fu_a=%h fu_b=%h res=%h flags=%b expected all 0",
                     busy, req_ready, rsp_valid, fu_a, fu_b, rsp_result, rsp_flags);
        end
        @(posedge clk); #1 reset_n = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            exp_rdy = (c == 0) ? 2'b01 : ((c == 4) ? 2'b10 : 2'b00);
            exp_rsp = (c == 3) ? 2'b01 : ((c == 7) ? 2'b10 : 2'b00);
            vec_cnt++;
            if ({req_ready, rsp_valid} !== {exp_rdy, exp_rsp}) begin
                err_cnt++;
                $display("FAIL rst_exec c%0d req_ready/rsp_valid: got %b/%b expected %b/%b",
                         c, req_ready, rsp_valid, exp_rdy, exp_rsp);
            end
            @(posedge clk); #1;
            if (c == 0) req_valid[0] = 1'b0;
            if (c == 4) req_valid[1] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fadd();
        test_fmul();
        test_fsub_flags();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fp_share_arbiter.md
Name: fp_share_arbiter

Overview:
Arbitrates between two requesters (core ALU issue port = port 0, coprocessor/vector port = port 1) for the single shared floating-point datapath (fp_add, fp_mul) that feeds ALU result mux codes 100/101. Accepts one operation at a time over valid/ready, holds operands stable for a fixed multi-cycle window so the FP units meet timing, and returns the result with {neg, zero} flags to the owning port over a separate valid/ready response channel. Round-robin fairness. At most one operation in flight.

Parameters:
WIDTH, 32, operand/result width (IEEE-754 single)
LATENCY, 2, cycles operands are held on fu_a/fu_b before result capture; legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
req0_valid, req1_valid  input  1 each  request pending
req0_ready, req1_ready  output  1 each  request accepted this cycle when valid&ready
req0_op, req1_op  input  2 each  00 fadd, 01 fmul, 10 fsub (a + (-b)), 11 reserved
req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands
rsp0_valid, rsp1_valid  output  1 each  result available for that port
rsp0_ready, rsp1_ready  input  1 each  requester consumes result
rsp_result  output  WIDTH  result, shared bus, qualified by rspN_valid
rsp_flags  output  2  {neg, zero} of rsp_result
fu_a, fu_b  output  WIDTH each  operands to fp_add/fp_mul (b sign-flipped for fsub)
fu_add_result, fu_mul_result  input  WIDTH each  combinational outputs of fp_add/fp_mul
busy  output  1  high in EXEC or RESP

Behaviour:
- Reset (async, reset_n=0): state IDLE, owner=0, last_grant=1 (port 0 wins first tie), counter=0, op/operand/result/flag registers=0; all outputs 0. Reset mid-operation aborts; no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE: grant selection is combinational. Only one valid: grant it. Both valid: grant the port != last_grant. reqN_ready = (state==IDLE) && grant==N; the other ready stays 0. Requesters hold valid/op/a/b until handshake. Arbiter samples only in the handshake cycle.
- On handshake: latch op, a, b (b[31] inverted when op=10), owner=N, last_grant=N, counter=LATENCY-1, go EXEC.
- EXEC: fu_a/fu_b driven from latched registers. fu_a/fu_b are always register outputs, stable for the whole op. Decrement counter each cycle.
- At counter==0 in EXEC:
  - Capture the result: fu_mul_result for op 01, fu_add_result for 00/10, 0 for 11.
  - Capture flags: neg=result[31]; zero=(result[30:0]==0), so -0.0 counts as zero.
  - Go RESP.
- RESP: rsp<owner>_valid=1; the other rsp valid stays 0. rsp_result/rsp_flags are held stable until rsp<owner>_ready=1, then go IDLE. Both ready inputs are ignored for the non-owner.
- No request is accepted during EXEC or RESP (ready=0).
- Timing: handshake at cycle t -> rsp_valid first high at t+LATENCY+1. If rsp_ready is high immediately, IDLE at t+LATENCY+2. The next handshake can occur at t+LATENCY+2.
- A request arriving while busy waits. Round-robin guarantees the waiting port wins the next tie.
- rsp_result/rsp_flags outside RESP hold the last captured value. Nothing is defined on them without valid.

Decomposition:
- Shared package/include holds:
  - op codes FP_ADD=2'b00, FP_MUL=2'b01, FP_SUB=2'b10, FP_RSVD=2'b11
  - state encodings S_IDLE/S_EXEC/S_RESP
  - flag bit indices FLAG_NEG=1, FLAG_ZERO=0
- One sub-module is natural: rr_arb2, the 2-way round-robin grant (inputs valid[1:0], last_grant; output grant index and any).
- fp_add/fp_mul stay outside, instantiated by the parent alongside the ALU.

Test Plan:
- Single fadd, LATENCY=2:
  - Stimulus: port0 a=0x3FC00000 (1.5), b=0x40100000 (2.25).
  - Expect: req0_ready in handshake cycle t; rsp0_valid at t+3; rsp_result=0x40700000 (3.75), flags=00.
- fmul on port1: a=0x40000000, b=0x40400000 -> rsp1_valid only, rsp_result=0x40C00000 (6.0); rsp0_valid stays 0 throughout.
- fsub/flags:
  - Stimulus: a=b=0x3F800000, op=10.
  - Expect: fu_b=0xBF800000, result=0, flags=01. Reserved op 11 -> result 0, flags=01.
- Simultaneous: both ports valid from reset.
  - Port0 served first, port1 accepted on the cycle after rsp0 handshake completes.
  - Then port0 re-requests while port1 is in flight; port0 is granted next (alternation).
- Backpressure: hold rsp0_ready=0 for 5 cycles in RESP.
  - rsp0_valid stays 1; rsp_result/flags stay constant; req0_ready/req1_ready stay 0.
  - IDLE the cycle after rsp0_ready=1.
- Reset mid-EXEC: drop reset_n during EXEC.
  - Outputs go 0 immediately (async), no rsp_valid after release.
  - First subsequent tie is granted to port0.
